mem_march_test: RTL and testbench



---
 rtl/mem_march_test.sv | 170 +++++++++++++++++
 tb/tb_mem_march_test.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_march_test.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_march_test: March C- self-test engine for an external RAM with        |
// | separate write/read ports and configurable read latency.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module mem_march_test #(
  parameter int                 ADDR_SZ  = 14,
  parameter int                 DATA_SZ  = 16,
  parameter int                 ADDR_MAX = 2**ADDR_SZ-1,
  parameter int                 RD_LAT   = 1,
  parameter logic [DATA_SZ-1:0] PATTERN  = {DATA_SZ{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  output logic               o_running,
  output logic               o_passed,
  output logic               o_failed,
  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  output logic [ADDR_SZ-1:0] o_fail_addr,
  output logic [DATA_SZ-1:0] o_fail_exp,
  output logic [DATA_SZ-1:0] o_fail_act
);

  localparam logic [1:0]         c_st_idle  = 2'd0;
  localparam logic [1:0]         c_st_run   = 2'd1;
  localparam logic [1:0]         c_st_pass  = 2'd2;
  localparam logic [1:0]         c_st_fail  = 2'd3;
  localparam int                 c_cnt_w    = $clog2(RD_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_lat      = c_cnt_w'(RD_LAT);
  localparam logic [ADDR_SZ-1:0] c_addr_max = ADDR_SZ'(ADDR_MAX);
  localparam logic [2:0]         c_last_el  = 3'd5;

  logic [1:0]         state_q, state_d;
  logic [2:0]         elem_q, elem_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               running_q, running_d;
  logic               passed_q, passed_d;
  logic               failed_q, failed_d;
  logic [ADDR_SZ-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_SZ-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_SZ-1:0] fail_act_q, fail_act_d;

  logic               w_in_run;
  logic               w_cmp;
  logic               w_mismatch;
  logic               w_down;
  logic [ADDR_SZ-1:0] w_end_addr;
  logic [DATA_SZ-1:0] w_exp_word;
  logic [DATA_SZ-1:0] w_wr_word;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= c_st_idle;
      elem_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      running_q   <= 1'b0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      running_q   <= running_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
    end
  end

  // Elements 3 and 4 walk down; 2 and 4 read "1", 1 and 3 write "1".
  always_comb begin
    w_in_run   = (state_q == c_st_run);
    w_down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    w_end_addr = w_down ? '0 : c_addr_max;
    w_exp_word = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~PATTERN : PATTERN;
    w_wr_word  = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~PATTERN : PATTERN;
    w_cmp      = w_in_run && (elem_q != 3'd0) && (cnt_q == c_lat);
    w_mismatch = w_cmp && (i_rdata != w_exp_word);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    running_d   = running_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    case (state_q)
      c_st_idle: begin
        if (i_run) begin
          state_d     = c_st_run;
          running_d   = 1'b1;
          passed_d    = 1'b0;
          failed_d    = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          elem_d      = '0;
          addr_d      = '0;
          cnt_d       = '0;
        end
      end
      c_st_run: begin
        if (w_mismatch) begin
          state_d     = c_st_fail;
          running_d   = 1'b0;
          failed_d    = 1'b1;
          fail_addr_d = addr_q;
          fail_exp_d  = w_exp_word;
          fail_act_d  = i_rdata;
        end else if ((elem_q == 3'd0) || w_cmp) begin
          cnt_d = '0;
          if (addr_q == w_end_addr) begin
            if (elem_q == c_last_el) begin
              state_d   = c_st_pass;
              running_d = 1'b0;
              passed_d  = 1'b1;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? c_addr_max : '0;
            end
          end else begin
            addr_d = w_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (!i_run) state_d = c_st_idle;
      end
    endcase
  end

  // Write is suppressed in a mismatch cycle so the failing cell stays intact.
  always_comb begin
    o_rd_en     = w_in_run && (elem_q != 3'd0) && (cnt_q == '0);
    o_raddr     = addr_q;
    o_wr_en     = w_in_run && ((elem_q == 3'd0) ||
                  (w_cmp && (elem_q != c_last_el) && !w_mismatch));
    o_waddr     = addr_q;
    o_wdata     = w_wr_word;
    o_running   = running_q;
    o_passed    = passed_q;
    o_failed    = failed_q;
    o_fail_addr = fail_addr_q;
    o_fail_exp  = fail_exp_q;
    o_fail_act  = fail_act_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_march_test.sv
`default_nettype none
// Directed bench for mem_march_test: ideal, faulty and latency-mismatched RAM
// models around a RD_LAT=1 instance and a RD_LAT=2 instance.
module tb_mem_march_test;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run1, run2;
  logic        running1, passed1, failed1, wr_en1, rd_en1;
  logic [3:0]  waddr1, raddr1, fail_addr1;
  logic [15:0] wdata1, rdata1, fail_exp1, fail_act1;
  logic        running2, passed2, failed2, wr_en2, rd_en2;
  logic [3:0]  waddr2, raddr2, fail_addr2;
  logic [15:0] wdata2, rdata2, fail_exp2, fail_act2;

  int total = 0;
  int bad   = 0;

  int          f_addr   = -1;
  logic [15:0] f_set    = 16'h0;
  logic [15:0] f_clr    = 16'h0;
  logic        lat2_sel = 1'b0;

  logic [3:0]  rq[$];
  logic [3:0]  wq[$];
  logic [15:0] wdq[$];
  logic        last_wr5;
  logic [3:0]  start_fa;
  logic        start_failed;

  mem_march_test #(.ADDR_SZ(4), .DATA_SZ(16), .ADDR_MAX(15), .RD_LAT(1),
                   .PATTERN(16'h0000)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_run(run1), .o_running(running1),
    .o_passed(passed1), .o_failed(failed1), .o_wr_en(wr_en1),
    .o_waddr(waddr1), .o_wdata(wdata1), .o_rd_en(rd_en1), .o_raddr(raddr1),
    .i_rdata(rdata1), .o_fail_addr(fail_addr1), .o_fail_exp(fail_exp1),
    .o_fail_act(fail_act1));

  mem_march_test #(.ADDR_SZ(4), .DATA_SZ(16), .ADDR_MAX(15), .RD_LAT(2),
                   .PATTERN(16'h0000)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_run(run2), .o_running(running2),
    .o_passed(passed2), .o_failed(failed2), .o_wr_en(wr_en2),
    .o_waddr(waddr2), .o_wdata(wdata2), .o_rd_en(rd_en2), .o_raddr(raddr2),
    .i_rdata(rdata2), .o_fail_addr(fail_addr2), .o_fail_exp(fail_exp2),
    .o_fail_act(fail_act2));

  // RAM models: stage 1 is a one-cycle read, stage 2 a two-cycle read.
  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];
  logic [15:0] s1_1, s1_2, s2_1, s2_2;

  function automatic logic [15:0] rd_fault(input logic [3:0] a, input logic [15:0] v);
    if (int'(a) == f_addr) return (v | f_set) & ~f_clr;
    return v;
  endfunction

  always @(posedge clk) begin
    if (wr_en1) mem1[waddr1] <= wdata1;
    s1_1 <= rd_en1 ? rd_fault(raddr1, mem1[raddr1]) : 16'hDEAD;
    s1_2 <= s1_1;
    if (wr_en2) mem2[waddr2] <= wdata2;
    s2_1 <= rd_en2 ? mem2[raddr2] : 16'hDEAD;
    s2_2 <= s2_1;
  end
  assign rdata1 = lat2_sel ? s1_2 : s1_1;
  assign rdata2 = s2_2;

  task automatic run_count(input int sel, output int cyc);
    cyc = 0;
    rq.delete(); wq.delete(); wdq.delete();
    last_wr5 = 1'b0;
    if (sel == 1) run1 = 1'b1; else run2 = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((sel == 1) ? running1 : running2) begin
        cyc++;
        if (sel == 1) begin
          if (cyc == 1) begin
            start_fa     = fail_addr1;
            start_failed = failed1;
          end
          if (rd_en1) rq.push_back(raddr1);
          if (wr_en1) begin
            wq.push_back(waddr1);
            wdq.push_back(wdata1);
          end
          last_wr5 = wr_en1 && (waddr1 == 4'd5);
        end
      end else if (cyc > 0) begin
        break;
      end
    end
  endtask

  task automatic go_idle();
    run1 = 1'b0;
    run2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; run1 = 1'b0; run2 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (running1 !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running1); end
    total++; if (passed1 !== 1'b0) begin bad++; $display("FAIL reset_passed got=%b want=0", passed1); end
    total++; if (failed1 !== 1'b0) begin bad++; $display("FAIL reset_failed got=%b want=0", failed1); end
    total++; if ({wr_en1, rd_en1, wr_en2, rd_en2} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b want=0000", {wr_en1, rd_en1, wr_en2, rd_en2}); end
    total++; if ({fail_addr1, fail_exp1, fail_act1} !== 36'h0) begin bad++; $display("FAIL reset_fail_rec got=%h want=0", {fail_addr1, fail_exp1, fail_act1}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass();
    int cyc, errs, idx;
    logic [3:0]  ea;
    logic [15:0] ed;
    run_count(1, cyc);
    total++; if (cyc != 176) begin bad++; $display("FAIL pass_cycles got=%0d want=176", cyc); end
    total++; if (passed1 !== 1'b1 || failed1 !== 1'b0) begin bad++; $display("FAIL pass_flags got=%b%b want=10", passed1, failed1); end
    total++; if (wq.size() != 80 || rq.size() != 80) begin bad++; $display("FAIL pass_access_count got=%0d/%0d want=80/80", wq.size(), rq.size()); end
    for (int e = 0; e < 5; e++) begin
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        idx = e * 16 + i;
        ea = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
        ed = (e == 1 || e == 3) ? 16'hFFFF : 16'h0000;
        if (idx >= wq.size()) errs++;
        else if (wq[idx] !== ea || wdq[idx] !== ed) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL write_seq_e%0d got=%0d bad entries want=0", e, errs); end
    end
    for (int e = 1; e < 6; e++) begin
      errs = 0;
      for (int i = 0; i < 16; i++) begin
        idx = (e - 1) * 16 + i;
        ea = (e == 3 || e == 4) ? 4'(15 - i) : 4'(i);
        if (idx >= rq.size()) errs++;
        else if (rq[idx] !== ea) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL read_seq_e%0d got=%0d bad entries want=0", e, errs); end
    end
    repeat (4) @(negedge clk);
    total++; if (running1 !== 1'b0 || passed1 !== 1'b1) begin bad++; $display("FAIL pass_hold got=%b%b want=01", running1, passed1); end
    run1 = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (running1 !== 1'b0 || passed1 !== 1'b1 || failed1 !== 1'b0) begin bad++; $display("FAIL idle_persist got=%b%b%b want=010", running1, passed1, failed1); end
  endtask

  task automatic test_stuck1();
    int cyc;
    go_idle();
    f_addr = 5; f_set = 16'h0008; f_clr = 16'h0000;
    run_count(1, cyc);
    total++; if (cyc != 28) begin bad++; $display("FAIL stuck1_cycles got=%0d want=28", cyc); end
    total++; if (failed1 !== 1'b1 || passed1 !== 1'b0) begin bad++; $display("FAIL stuck1_flags got=%b%b want=01", passed1, failed1); end
    total++; if (fail_addr1 !== 4'd5) begin bad++; $display("FAIL stuck1_addr got=%0d want=5", fail_addr1); end
    total++; if (fail_exp1 !== 16'h0000) begin bad++; $display("FAIL stuck1_exp got=%h want=0000", fail_exp1); end
    total++; if (fail_act1 !== 16'h0008) begin bad++; $display("FAIL stuck1_act got=%h want=0008", fail_act1); end
    total++; if (last_wr5 !== 1'b0) begin bad++; $display("FAIL stuck1_no_write got=%b want=0", last_wr5); end
    f_addr = -1; f_set = 16'h0000;
  endtask

  task automatic test_stuck0();
    int cyc;
    go_idle();
    f_addr = 15; f_set = 16'h0000; f_clr = 16'h0001;
    run_count(1, cyc);
    total++; if (start_failed !== 1'b0 || start_fa !== 4'd0) begin bad++; $display("FAIL start_clear got=%b/%0d want=0/0", start_failed, start_fa); end
    total++; if (cyc != 80) begin bad++; $display("FAIL stuck0_cycles got=%0d want=80", cyc); end
    total++; if (failed1 !== 1'b1 || fail_addr1 !== 4'd15) begin bad++; $display("FAIL stuck0_addr got=%b/%0d want=1/15", failed1, fail_addr1); end
    total++; if (fail_exp1 !== 16'hFFFF || fail_act1 !== 16'hFFFE) begin bad++; $display("FAIL stuck0_data got=%h/%h want=ffff/fffe", fail_exp1, fail_act1); end
    f_addr = -1; f_clr = 16'h0000;
  endtask

  task automatic test_lat_mismatch();
    int cyc;
    go_idle();
    lat2_sel = 1'b1;
    run_count(1, cyc);
    total++; if (cyc != 18) begin bad++; $display("FAIL latmis_cycles got=%0d want=18", cyc); end
    total++; if (failed1 !== 1'b1 || passed1 !== 1'b0) begin bad++; $display("FAIL latmis_flags got=%b%b want=01", passed1, failed1); end
    total++; if (fail_addr1 !== 4'd0 || fail_exp1 !== 16'h0000) begin bad++; $display("FAIL latmis_rec got=%0d/%h want=0/0000", fail_addr1, fail_exp1); end
    lat2_sel = 1'b0;
  endtask

  task automatic test_lat2();
    int cyc;
    go_idle();
    run_count(2, cyc);
    total++; if (cyc != 256) begin bad++; $display("FAIL lat2_cycles got=%0d want=256", cyc); end
    total++; if (passed2 !== 1'b1 || failed2 !== 1'b0) begin bad++; $display("FAIL lat2_flags got=%b%b want=10", passed2, failed2); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    go_idle();
    run1 = 1'b1;
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (running1) cyc++;
      if (cyc == 40) break;
    end
    total++; if (cyc != 40) begin bad++; $display("FAIL midrun_reach got=%0d want=40", cyc); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({running1, passed1, failed1, wr_en1, rd_en1} !== 5'b0) begin bad++; $display("FAIL midrun_reset got=%b want=00000", {running1, passed1, failed1, wr_en1, rd_en1}); end
    total++; if ({fail_addr1, fail_exp1, fail_act1} !== 36'h0) begin bad++; $display("FAIL midrun_rec got=%h want=0", {fail_addr1, fail_exp1, fail_act1}); end
    rst = 1'b0;
    run_count(1, cyc);
    total++; if (cyc != 176 || passed1 !== 1'b1) begin bad++; $display("FAIL midrun_restart got=%0d/%b want=176/1", cyc, passed1); end
  endtask

  initial begin
    rst = 1'b1; run1 = 1'b0; run2 = 1'b0;
    test_reset();
    test_pass();
    test_stuck1();
    test_stuck0();
    test_lat_mismatch();
    test_lat2();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
